// File: rtl/axis_packet_gen_if.sv
// AXI-Stream bundle carrying packet beats from the generator toward the mesh ingress.
// The master modport drives the beat fields; the slave modport returns tready.
interface axis_packet_gen_if #(
    parameter int TDATA_WIDTH = 512,
    parameter int TDEST_WIDTH = 4
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TDEST_WIDTH-1:0] tdest;

    modport master (output tvalid, output tdata, output tlast, output tdest, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tdest, output tready);
endinterface

// File: rtl/axis_packet_gen.sv
// Burst traffic generator: emits num_packets packets of pkt_len beats each, with the
// destination cycling round-robin over the mesh endpoints (optionally skipping itself).
module axis_packet_gen #(
    parameter int TDEST_WIDTH = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int NUM_DESTS   = 4,
    parameter int SRC_ID      = 0,
    parameter bit SKIP_SELF   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [15:0]              num_packets,
    input  logic [7:0]               pkt_len,
    axis_packet_gen_if.master        axis_out,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              pkts_sent
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam bit DO_SKIP = SKIP_SELF && (NUM_DESTS > 1);
    localparam logic [TDEST_WIDTH-1:0] FIRST_DEST =
        (DO_SKIP && SRC_ID == 0) ? TDEST_WIDTH'(1) : TDEST_WIDTH'(0);

    state_t                 state_reg;
    logic [15:0]            num_pkts_reg;
    logic [7:0]             eff_len_reg;
    logic [7:0]             beat_reg;
    logic [15:0]            seq_reg;
    logic [15:0]            pkts_sent_reg;
    logic                   tvalid_reg;
    logic                   tlast_reg;
    logic [TDATA_WIDTH-1:0] tdata_reg;
    logic [TDEST_WIDTH-1:0] tdest_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic [7:0]             len_eff;

    assign len_eff = (pkt_len == 8'd0) ? 8'd1 : pkt_len;

    // Round-robin successor; a second hop is enough because only one endpoint is skipped.
    function automatic logic [TDEST_WIDTH-1:0] step_dest(input logic [TDEST_WIDTH-1:0] d);
        logic [TDEST_WIDTH-1:0] n;
        n = (int'(d) >= NUM_DESTS - 1) ? TDEST_WIDTH'(0) : d + TDEST_WIDTH'(1);
        if (DO_SKIP && int'(n) == SRC_ID) begin
            n = (int'(n) >= NUM_DESTS - 1) ? TDEST_WIDTH'(0) : n + TDEST_WIDTH'(1);
        end
        return n;
    endfunction

    function automatic logic [TDATA_WIDTH-1:0] payload(input logic [7:0] beat,
                                                       input logic [15:0] seq);
        logic [TDATA_WIDTH-1:0] p;
        p        = '0;
        p[15:0]  = {8'h00, beat};
        p[31:16] = seq;
        p[47:32] = 16'(SRC_ID);
        p[63:48] = 16'hA5A5;
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            num_pkts_reg  <= '0;
            eff_len_reg   <= '0;
            beat_reg      <= '0;
            seq_reg       <= '0;
            pkts_sent_reg <= '0;
            tvalid_reg    <= 1'b0;
            tlast_reg     <= 1'b0;
            tdata_reg     <= '0;
            tdest_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        num_pkts_reg  <= num_packets;
                        eff_len_reg   <= len_eff;
                        beat_reg      <= '0;
                        seq_reg       <= '0;
                        pkts_sent_reg <= '0;
                        tdest_reg     <= FIRST_DEST;
                        tdata_reg     <= payload(8'd0, 16'd0);
                        busy_reg      <= 1'b1;
                        if (num_packets == 16'd0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg  <= SEND;
                            tvalid_reg <= 1'b1;
                            tlast_reg  <= (len_eff == 8'd1);
                        end
                    end
                end
                SEND: begin
                    // tvalid is held high for the whole of SEND, so tready alone marks a handshake.
                    if (axis_out.tready) begin
                        if (tlast_reg) begin
                            pkts_sent_reg <= pkts_sent_reg + 16'd1;
                            if (seq_reg == num_pkts_reg - 16'd1) begin
                                state_reg  <= DONE;
                                tvalid_reg <= 1'b0;
                                tlast_reg  <= 1'b0;
                                done_reg   <= 1'b1;
                            end else begin
                                seq_reg   <= seq_reg + 16'd1;
                                beat_reg  <= '0;
                                tdest_reg <= step_dest(tdest_reg);
                                tdata_reg <= payload(8'd0, seq_reg + 16'd1);
                                tlast_reg <= (eff_len_reg == 8'd1);
                            end
                        end else begin
                            beat_reg  <= beat_reg + 8'd1;
                            tdata_reg <= payload(beat_reg + 8'd1, seq_reg);
                            tlast_reg <= (beat_reg + 8'd2 == eff_len_reg);
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign axis_out.tvalid = tvalid_reg;
    assign axis_out.tlast  = tlast_reg;
    assign axis_out.tdata  = tdata_reg;
    assign axis_out.tdest  = tdest_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign pkts_sent       = pkts_sent_reg;

endmodule
